// File: rtl/a2d_intf.sv
// a2d_intf: round-robin four-channel front end for an ADC128S-style SPI A2D (mode 3 master).
// Build macro A2D_CURR_AVG_EN turns curr into a running average of the last four ch1 results.
module a2d_intf #(
  parameter int SCLK_DIV    = 32,
  parameter int CONV_PERIOD = 14
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        A2D_SS_n,
  output logic        A2D_SCLK,
  output logic        A2D_MOSI,
  input  logic        A2D_MISO,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        cnv_cmplt
);

  // state | meaning
  // IDLE  | waiting for trigger counter to reach all-ones
  // TX1   | first frame; sets up the channel, read data ignored
  // GAP   | SS_n high for SCLK_DIV clks between frames
  // TX2   | second frame; shifts in the conversion result
  // DONE  | latch result, pulse cnv_cmplt, advance pointer

  localparam int DW = $clog2(SCLK_DIV);
  localparam logic [DW-1:0] DIV_LOAD = DW'(SCLK_DIV - 9);
  localparam logic [DW-1:0] DIV_SMPL = DW'(SCLK_DIV / 2 - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, TX1, GAP, TX2, DONE} state_t;

  state_t                 state;
  logic [CONV_PERIOD-1:0] trig_cnt;
  logic [DW-1:0]          div;
  logic [DW-1:0]          gap_cnt;
  logic [4:0]             smpl_cnt;
  logic [15:0]            tx_sh;
  logic [11:0]            rx_sh;
  logic [1:0]             ptr;
  logic [2:0]             ch;
  logic [15:0]            cmd;

`ifdef A2D_CURR_AVG_EN
  logic [11:0] hist0, hist1, hist2;
  logic [13:0] avg_sum;
  assign avg_sum = {2'b00, rx_sh} + {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2};
`endif

  always_comb begin
    case (ptr)
      2'd0:    ch = 3'd0;
      2'd1:    ch = 3'd1;
      2'd2:    ch = 3'd3;
      default: ch = 3'd4;
    endcase
  end

  assign cmd = {2'b00, ch, 11'h000};

  // Divider idles at DIV_LAST so its MSB holds SCLK high outside a frame.
  assign A2D_SCLK = div[DW-1];
  assign A2D_MOSI = tx_sh[15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      trig_cnt  <= '0;
      div       <= DIV_LAST;
      gap_cnt   <= '0;
      smpl_cnt  <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      ptr       <= 2'd0;
      A2D_SS_n  <= 1'b1;
      batt      <= '0;
      curr      <= '0;
      brake     <= '0;
      torque    <= '0;
      cnv_cmplt <= 1'b0;
`ifdef A2D_CURR_AVG_EN
      hist0     <= '0;
      hist1     <= '0;
      hist2     <= '0;
`endif
    end else begin
      trig_cnt  <= trig_cnt + CONV_PERIOD'(1);
      cnv_cmplt <= 1'b0;
      case (state)
        IDLE: begin
          if (&trig_cnt) begin
            A2D_SS_n <= 1'b0;
            div      <= DIV_LOAD;
            tx_sh    <= cmd;
            smpl_cnt <= '0;
            state    <= TX1;
          end
        end
        TX1, TX2: begin
          if (div == DIV_SMPL) begin
            rx_sh    <= {rx_sh[10:0], A2D_MISO};
            smpl_cnt <= smpl_cnt + 5'd1;
          end
          if (div == DIV_LAST) begin
            if (smpl_cnt == 5'd16) begin
              // Back porch ends: release SS_n instead of letting SCLK fall.
              A2D_SS_n <= 1'b1;
              tx_sh    <= '0;
              if (state == TX1) begin
                gap_cnt <= DIV_LAST;
                state   <= GAP;
              end else begin
                state <= DONE;
              end
            end else begin
              div <= '0;
              if (smpl_cnt != 5'd0) tx_sh <= {tx_sh[14:0], 1'b0};
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            A2D_SS_n <= 1'b0;
            div      <= DIV_LOAD;
            tx_sh    <= cmd;
            smpl_cnt <= '0;
            state    <= TX2;
          end else begin
            gap_cnt <= gap_cnt - DW'(1);
          end
        end
        DONE: begin
          case (ptr)
            2'd0: batt <= rx_sh;
            2'd1: begin
`ifdef A2D_CURR_AVG_EN
              curr  <= avg_sum[13:2];
              hist2 <= hist1;
              hist1 <= hist0;
              hist0 <= rx_sh;
`else
              curr <= rx_sh;
`endif
            end
            2'd2:    brake  <= rx_sh;
            default: torque <= rx_sh;
          endcase
          cnv_cmplt <= 1'b1;
          ptr       <= ptr + 2'd1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_intf.sv
// Directed bench for a2d_intf with a clock-sampled SPI A2D model returning 12'hC00|ch.
module tb_a2d_intf;

  localparam int SCLK_DIV = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ss_n, sclk, mosi, cnv;
  logic        miso = 1'b0;
  logic [11:0] batt, curr, brake, torque;

  a2d_intf #(.SCLK_DIV(SCLK_DIV), .CONV_PERIOD(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .A2D_SS_n(ss_n), .A2D_SCLK(sclk), .A2D_MOSI(mosi), .A2D_MISO(miso),
    .batt(batt), .curr(curr), .brake(brake), .torque(torque),
    .cnv_cmplt(cnv)
  );

  always #10 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [11:0] val [0:7];
  logic [15:0] fr_cmd  [0:127];
  int          fr_bits [0:127];
  int          fr_gap  [0:127];
  int          frames = 0, starts = 0, nrise = 0, nfall = 0, gap = 0;
  int          pulses = 0, dbl = 0;
  logic [15:0] sh_in = '0, sh_out = '0;
  logic [2:0]  last_ch = 3'd0;
  logic        ss_q = 1'b1, sclk_q = 1'b1, cnv_q = 1'b0;

  // A2D model: edges of SS_n/SCLK are detected on the falling clk edge.
  always @(negedge clk) begin
    if (ss_q && !ss_n) begin
      fr_gap[frames % 128] = gap;
      starts++;
      nrise  = 0;
      nfall  = 0;
      sh_in  = '0;
      sh_out = {4'h0, val[last_ch]};
      miso   = sh_out[15];
    end
    if (!ss_n && sclk_q && !sclk) begin
      nfall++;
      if (nfall > 1) sh_out = {sh_out[14:0], 1'b0};
      miso = sh_out[15];
    end
    if (!ss_n && !sclk_q && sclk) begin
      sh_in = {sh_in[14:0], mosi};
      nrise++;
    end
    if (!ss_q && ss_n) begin
      fr_cmd[frames % 128]  = sh_in;
      fr_bits[frames % 128] = nrise;
      frames++;
      if (nrise == 16) last_ch = sh_in[13:11];
      gap = 0;
    end
    if (ss_n) gap++;
    if (cnv) begin
      pulses++;
      if (cnv_q) dbl++;
    end
    ss_q   = ss_n;
    sclk_q = sclk;
    cnv_q  = cnv;
  end

  logic [11:0] e_batt, e_curr, e_brake, e_torque;
  logic [11:0] eh0, eh1, eh2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_exp();
    e_batt = '0; e_curr = '0; e_brake = '0; e_torque = '0;
    eh0 = '0; eh1 = '0; eh2 = '0;
  endtask

  task automatic exp_update(input logic [2:0] c, input logic [11:0] v);
    logic [13:0] s;
    case (c)
      3'd0: e_batt = v;
      3'd1: begin
`ifdef A2D_CURR_AVG_EN
        s = {2'b00, v} + {2'b00, eh0} + {2'b00, eh1} + {2'b00, eh2};
        e_curr = s[13:2];
        eh2 = eh1; eh1 = eh0; eh0 = v;
`else
        s = '0;
        e_curr = v;
`endif
      end
      3'd3:    e_brake  = v;
      default: e_torque = v;
    endcase
  endtask

  task automatic wait_conv(output bit ok);
    int p0;
    p0 = pulses;
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      #1;
      if (pulses != p0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic conv_step(input logic [2:0] c, input string tag);
    bit          ok;
    logic [15:0] ecmd;
    ecmd = {2'b00, c, 11'h000};
    wait_conv(ok);
    chk({tag, "_timeout"}, 32'(ok), 32'd1);
    exp_update(c, val[c]);
    if (frames >= 2) begin
      chk({tag, "_tx1_cmd"},  32'(fr_cmd[(frames - 2) % 128]), 32'(ecmd));
      chk({tag, "_tx2_cmd"},  32'(fr_cmd[(frames - 1) % 128]), 32'(ecmd));
      chk({tag, "_tx1_bits"}, fr_bits[(frames - 2) % 128], 32'd16);
      chk({tag, "_tx2_bits"}, fr_bits[(frames - 1) % 128], 32'd16);
      chk({tag, "_gap"},      fr_gap[(frames - 1) % 128], 32'(SCLK_DIV));
    end
    chk({tag, "_batt"},   32'(batt),   32'(e_batt));
    chk({tag, "_curr"},   32'(curr),   32'(e_curr));
    chk({tag, "_brake"},  32'(brake),  32'(e_brake));
    chk({tag, "_torque"}, 32'(torque), 32'(e_torque));
    chk({tag, "_dbl_pulse"}, dbl, 32'd0);
  endtask

  logic [11:0] avg_tab [0:3];
  int          target;
  bit          found;

  initial begin
    for (int i = 0; i < 8; i++) val[i] = 12'hC00 | 12'(i);
`ifdef A2D_CURR_AVG_EN
    avg_tab[0] = 12'h200; avg_tab[1] = 12'h400; avg_tab[2] = 12'h600; avg_tab[3] = 12'h800;
`else
    avg_tab[0] = 12'h800; avg_tab[1] = 12'h800; avg_tab[2] = 12'h800; avg_tab[3] = 12'h800;
`endif
    clear_exp();

    // 1: reset state and quiet bus until first counter wrap
    #1 rst_n = 1'b0;
    #34;
    chk("rst_ss_n", 32'(ss_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd1);
    chk("rst_mosi", 32'(mosi), 32'd0);
    chk("rst_batt", 32'(batt), 32'd0);
    chk("rst_curr", 32'(curr), 32'd0);
    chk("rst_brake", 32'(brake), 32'd0);
    chk("rst_torque", 32'(torque), 32'd0);
    chk("rst_cnv", 32'(cnv), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (250) @(negedge clk);
    #1;
    chk("no_early_ss", starts, 32'd0);
    chk("idle_ss_n", 32'(ss_n), 32'd1);

    // 2/3: first conversion then full round robin
    conv_step(3'd0, "t2_ch0");
    chk("t2_batt_c00", 32'(batt), 32'h0C00);
    chk("t2_one_pulse", pulses, 32'd1);
    conv_step(3'd1, "t3_ch1");
    conv_step(3'd3, "t3_ch3");
    conv_step(3'd4, "t3_ch4");
    chk("t3_torque_c04", 32'(torque), 32'h0C04);
    conv_step(3'd0, "t3_ch0_again");

    // 4: ch4 value changes; only torque follows
    val[4] = 12'hFFF;
    conv_step(3'd1, "t4_ch1");
    conv_step(3'd3, "t4_ch3");
    conv_step(3'd4, "t4_ch4");
    chk("t4_torque_fff", 32'(torque), 32'h0FFF);
    chk("t4_batt_kept", 32'(batt), 32'h0C00);

    // 5: reset during bit 7 of the next conversion's TX2
    target = starts + 2;
    found  = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (starts == target && nrise == 7) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_reach_tx2_bit7", 32'(found), 32'd1);
    #1 rst_n = 1'b0;
    #3;
    chk("t5_ss_n", 32'(ss_n), 32'd1);
    chk("t5_sclk", 32'(sclk), 32'd1);
    chk("t5_batt", 32'(batt), 32'd0);
    chk("t5_curr", 32'(curr), 32'd0);
    chk("t5_brake", 32'(brake), 32'd0);
    chk("t5_torque", 32'(torque), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_exp();
    val[1] = 12'h800;
    conv_step(3'd0, "t5_ch0_first");

    // 6: four ch1 updates with 12'h800
    for (int r = 0; r < 4; r++) begin
      if (r > 0) begin
        conv_step(3'd3, "t6_ch3");
        conv_step(3'd4, "t6_ch4");
        conv_step(3'd0, "t6_ch0");
      end
      conv_step(3'd1, "t6_ch1");
      chk($sformatf("t6_curr_%0d", r), 32'(curr), 32'(avg_tab[r]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
